// File: rtl/mod_timer_ctrl_pkg.sv
// Shared types and default widths for the programmable timer controller.
package mod_timer_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned PRE_W_DEF = 4;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // True in the states where a new configuration or a start may be taken
    function automatic logic is_idle_like(input state_e st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/mod_timer_ctrl_cnt_core.sv
// Modulo counter with prescaler: counts 0..term, one step per pre+1 enabled clocks.
module timer_cnt_core
    import mod_timer_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             reload_i,
    input  logic [CNT_W-1:0] term_i,
    input  logic [PRE_W-1:0] pre_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_c_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             step_c;

    // A count step happens when the prescaler reaches its programmed limit
    assign step_c   = en_i && (pre_q == pre_i);
    assign wrap_c_o = step_c && (cnt_q == term_i);
    assign count_o  = cnt_q;

    // Next-state for counter and prescaler; clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        pre_d = pre_q;
        if (clear_i) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (en_i) begin
            if (step_c) begin
                pre_d = '0;
                if (cnt_q == term_i) begin
                    // One-shot runs park on the terminal value
                    cnt_d = reload_i ? '0 : cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Counter and prescaler registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_timer_ctrl.sv
// Timer controller: config handshake, run sequencing, terminal tick and sticky irq.
module mod_timer_ctrl
    import mod_timer_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_term,
    input  logic [PRE_W-1:0] cfg_pre,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] term_q, term_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             periodic_q, periodic_d;
    logic             tick_q, tick_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             cfg_fire_c;
    logic             idle_like_c;
    logic             core_clear_c;
    logic             core_en_c;
    logic             wrap_c;

    assign idle_like_c  = is_idle_like(state_q);
    assign cfg_fire_c   = cfg_valid && ready_q;
    assign core_clear_c = stop || (start && idle_like_c);
    // Stop suppresses any step, and hence any wrap, in its cycle
    assign core_en_c    = (state_q == ST_RUN) && !pause && !stop;

    timer_cnt_core #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (core_clear_c),
        .en_i     (core_en_c),
        .reload_i (periodic_q),
        .term_i   (term_q),
        .pre_i    (pre_q),
        .count_o  (count),
        .wrap_c_o (wrap_c)
    );

    // Next-state, config latch, tick/irq and status decode
    always_comb begin
        state_d    = state_q;
        term_d     = term_q;
        pre_d      = pre_q;
        periodic_d = periodic_q;
        tick_d     = wrap_c;
        irq_d      = tick_q || (irq_q && !irq_clr);

        if (cfg_fire_c) begin
            term_d     = cfg_term;
            pre_d      = cfg_pre;
            periodic_d = cfg_periodic;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (wrap_c && !periodic_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d  = (state_d == ST_DONE);
        ready_d = is_idle_like(state_d);
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            term_q     <= '0;
            pre_q      <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            term_q     <= term_d;
            pre_q      <= pre_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign cfg_ready = ready_q;
    assign tick      = tick_q;
    assign irq       = irq_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mod_timer_ctrl.sv
// Directed bench for mod_timer_ctrl with hand-computed expectations.
module tb_mod_timer_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PRE_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_term;
    logic [PRE_W-1:0] cfg_pre;
    logic             cfg_periodic;
    logic             start;
    logic             stop;
    logic             pause;
    logic             irq_clr;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;
    logic             irq;

    int checks = 0;
    int errors = 0;

    mod_timer_ctrl #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_term     (cfg_term),
        .cfg_pre      (cfg_pre),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .irq_clr      (irq_clr),
        .count        (count),
        .tick         (tick),
        .busy         (busy),
        .done         (done),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int t, input int p, input logic per);
        cfg_valid    = 1'b1;
        cfg_term     = CNT_W'(t);
        cfg_pre      = PRE_W'(p);
        cfg_periodic = per;
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_term = '0; cfg_pre = '0;
        cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; irq_clr = 1'b0;
        step(); step();
        chk("rst_count", 32'(count), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        reset_n = 1'b1;
        step();

        // Periodic T=3 P=0, config and start in the same cycle
        offer(3, 0, 1'b1); start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk("t1_count", 32'(count), 32'((k - 1) % 4));
            chk("t1_tick", 32'(tick), 32'(k == 5 || k == 9 || k == 13));
            chk("t1_irq", 32'(irq), 32'(k >= 6 && k <= 14));
            chk("t1_busy", 32'(busy), 1);
            irq_clr = (k == 13 || k == 14);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t1_stop_busy", 32'(busy), 0);
        chk("t1_stop_count", 32'(count), 0);

        // One-shot T=2 P=1
        offer(2, 1, 1'b0); start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk("t2_count", 32'(count), 32'(k < 3 ? 0 : (k < 5 ? 1 : 2)));
            chk("t2_tick", 32'(tick), 32'(k == 7));
            chk("t2_done", 32'(done), 32'(k >= 7));
            chk("t2_busy", 32'(busy), 32'(k < 7));
            chk("t2_irq", 32'(irq), 32'(k >= 8));
            step();
        end
        chk("t2_ready_done", 32'(cfg_ready), 1);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("t2_irq_clr", 32'(irq), 0);

        // Pause T=9 periodic, started straight from DONE
        offer(9, 0, 1'b1); start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("t3_count", 32'(count), 32'(k <= 4 ? k - 1 : (k <= 8 ? 3 : k - 5)));
            chk("t3_busy", 32'(busy), 1);
            chk("t3_tick", 32'(tick), 0);
            chk("t3_done", 32'(done), 0);
            pause = (k >= 4 && k <= 6);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Stop on the wrap cycle, T=1 periodic
        offer(1, 0, 1'b1); start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t4_count1", 32'(count), 0);
        step();
        chk("t4_count2", 32'(count), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_count", 32'(count), 0);
        chk("t4_tick", 32'(tick), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 0);
        step();
        chk("t4_tick_late", 32'(tick), 0);
        chk("t4_irq", 32'(irq), 0);

        // Config offer during RUN is refused
        offer(3, 0, 1'b1); start = 1'b1;
        step();
        start = 1'b0;
        offer(5, 0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            chk("t5_ready", 32'(cfg_ready), 0);
            chk("t5_count", 32'(count), 32'((k - 1) % 4));
            chk("t5_tick", 32'(tick), 32'(k == 5));
            if (k == 5) begin
                cfg_valid = 1'b0;
                stop = 1'b1;
            end
            step();
        end
        stop = 1'b0;
        chk("t5_ready_idle", 32'(cfg_ready), 1);
        chk("t5_idle_count", 32'(count), 0);
        chk("t5_irq", 32'(irq), 1);
        offer(5, 0, 1'b0);
        step();
        cfg_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("t5b_count", 32'(count), 32'(k - 1 < 5 ? k - 1 : 5));
            chk("t5b_tick", 32'(tick), 32'(k == 7));
            chk("t5b_done", 32'(done), 32'(k >= 7));
            step();
        end

        // Reset mid-run, then defaults (T=0 one-shot) and T=0 periodic
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("t6_count_pre", 32'(count), 2);
        chk("t6_irq_pre", 32'(irq), 1);
        reset_n = 1'b0;
        step();
        chk("t6_count", 32'(count), 0);
        chk("t6_tick", 32'(tick), 0);
        chk("t6_irq", 32'(irq), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_ready", 32'(cfg_ready), 1);
        reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_t0_count", 32'(count), 0);
        chk("t6_t0_busy", 32'(busy), 1);
        step();
        chk("t6_t0_tick", 32'(tick), 1);
        chk("t6_t0_done", 32'(done), 1);
        chk("t6_t0_busy2", 32'(busy), 0);

        offer(0, 0, 1'b1); start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t7_count", 32'(count), 0);
        chk("t7_tick0", 32'(tick), 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("t7_tick", 32'(tick), 1);
            chk("t7_count_k", 32'(count), 0);
            chk("t7_busy", 32'(busy), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
